// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared control definitions for the PC redirect path.
//   redir_state_t : redirect sequencer states (IDLE, PEND, FLUSH)
//   FLUSH_CNT_W   : width of the post-acceptance flush countdown
package riscv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } redir_state_t;

    localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter used for branch/jump statistics.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears count
//   inc   : increment request for this cycle
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences the PC redirect from the EX-stage branch unit to the IF PC register.
// A taken branch/jump in IDLE is captured, presented to fetch until accepted,
// then IF/ID and ID/EX are flushed for FLUSH_CYCLES cycles while wrong-path
// redirects are ignored.
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   ex_valid       : EX holds a valid instruction
//   PcSel          : branch/jump taken
//   JalSel         : instruction is jal/jalr
//   BrPC           : branch target address
//   fetch_ready    : IF accepts redirect_pc this cycle
//   redirect_valid : redirect_pc must be loaded into the PC
//   redirect_pc    : captured target, word aligned
//   flush_ifid     : squash IF/ID
//   flush_idex     : squash ID/EX
//   busy           : sequencer not idle
//   target_err     : sticky misaligned / out-of-range target flag
//   br_taken_cnt   : saturating count of taken conditional branches
//   jump_cnt       : saturating count of taken jal/jalr
module branch_redirect_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned PC_W         = 9,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             PcSel,
    input  logic             JalSel,
    input  logic [31:0]      BrPC,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic             target_err,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] jump_cnt
);

    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15)) begin : g_bad_flush_cycles
        $error("branch_redirect_ctrl: FLUSH_CYCLES must be in 1..15");
    end

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    redir_state_t           state, state_nxt;
    logic [FLUSH_CNT_W-1:0] cnt, cnt_nxt;
    logic                   capture;
    logic                   tgt_bad;

    // Only IDLE may capture; anything seen in PEND/FLUSH is wrong-path.
    assign capture = (state == IDLE) && ex_valid && PcSel;
    assign tgt_bad = (BrPC[1:0] != 2'b00) || (BrPC[31:PC_W] != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        redirect_valid = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                redirect_valid = 1'b1;
                flush_ifid     = 1'b1;
                flush_idex     = 1'b1;
                busy           = 1'b1;
                if (fetch_ready) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                busy       = 1'b1;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_pc <= '0;
            target_err  <= 1'b0;
        end else if (capture) begin
            redirect_pc <= {BrPC[PC_W-1:2], 2'b00};
            if (tgt_bad) begin
                target_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (capture && !JalSel),
        .count (br_taken_cnt)
    );

    sat_counter #(.W(CNT_W)) u_jump_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (capture && JalSel),
        .count (jump_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    localparam int unsigned PC_W  = 9;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             ex_valid;
    logic             PcSel;
    logic             JalSel;
    logic [31:0]      BrPC;
    logic             fetch_ready;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush_ifid;
    logic             flush_idex;
    logic             busy;
    logic             target_err;
    logic [CNT_W-1:0] br_taken_cnt;
    logic [CNT_W-1:0] jump_cnt;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned exp_br;
    int unsigned exp_jmp;

    branch_redirect_ctrl #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .PcSel          (PcSel),
        .JalSel         (JalSel),
        .BrPC           (BrPC),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .busy           (busy),
        .target_err     (target_err),
        .br_taken_cnt   (br_taken_cnt),
        .jump_cnt       (jump_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump(input logic jal);
        if (jal) begin
            if (exp_jmp < 15) exp_jmp++;
        end else begin
            if (exp_br < 15) exp_br++;
        end
    endtask

    // Full redirect with immediate acceptance: capture, PEND, 2x FLUSH, back to IDLE.
    task automatic do_redirect(input logic [31:0] pc, input logic jal);
        ex_valid    = 1'b1;
        PcSel       = 1'b1;
        JalSel      = jal;
        BrPC        = pc;
        fetch_ready = 1'b1;
        tick();
        bump(jal);
        ex_valid = 1'b0;
        PcSel    = 1'b0;
        JalSel   = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic check_outs(input string tag, input logic v, input logic f, input logic b);
        check_eq({tag, ".valid"}, 32'(redirect_valid), 32'(v));
        check_eq({tag, ".ifid"},  32'(flush_ifid),     32'(f));
        check_eq({tag, ".idex"},  32'(flush_idex),     32'(f));
        check_eq({tag, ".busy"},  32'(busy),           32'(b));
    endtask

    task automatic check_cnts(input string tag);
        check_eq({tag, ".br_cnt"},  32'(br_taken_cnt), exp_br);
        check_eq({tag, ".jmp_cnt"}, 32'(jump_cnt),     exp_jmp);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        exp_br      = 0;
        exp_jmp     = 0;
        reset       = 1'b0;
        ex_valid    = 1'b0;
        PcSel       = 1'b0;
        JalSel      = 1'b0;
        BrPC        = '0;
        fetch_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        check_outs("rst_state", 1'b0, 1'b0, 1'b0);
        check_eq("rst_pc", 32'(redirect_pc), 32'h0);
        check_eq("rst_err", 32'(target_err), 32'h0);
        check_cnts("rst");

        // 1: async reset mid-PEND drops the redirect
        ex_valid = 1'b1; PcSel = 1'b1; BrPC = 32'h40;
        tick();
        ex_valid = 1'b0; PcSel = 1'b0;
        check_outs("t1_pend", 1'b1, 1'b1, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check_outs("t1_async", 1'b0, 1'b0, 1'b0);
        check_eq("t1_async_pc", 32'(redirect_pc), 32'h0);
        check_eq("t1_async_br", 32'(br_taken_cnt), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check_outs("t1_after", 1'b0, 1'b0, 1'b0);

        // IDLE no-ops: missing ex_valid, or JalSel without PcSel
        ex_valid = 1'b0; PcSel = 1'b1; BrPC = 32'h80;
        tick();
        check_outs("noop_exv", 1'b0, 1'b0, 1'b0);
        ex_valid = 1'b1; PcSel = 1'b0; JalSel = 1'b1;
        tick();
        ex_valid = 1'b0; JalSel = 1'b0;
        check_outs("noop_pcsel", 1'b0, 1'b0, 1'b0);
        check_cnts("noop");

        // 2: basic redirect with latency 1 and a 2-cycle drain
        ex_valid = 1'b1; PcSel = 1'b1; JalSel = 1'b0; BrPC = 32'h40; fetch_ready = 1'b1;
        tick();
        bump(1'b0);
        ex_valid = 1'b0; PcSel = 1'b0;
        check_outs("t2_c1", 1'b1, 1'b1, 1'b1);
        check_eq("t2_pc", 32'(redirect_pc), 32'h040);
        check_cnts("t2");
        tick();
        check_outs("t2_c2", 1'b0, 1'b1, 1'b1);
        tick();
        check_outs("t2_c3", 1'b0, 1'b1, 1'b1);
        tick();
        check_outs("t2_c4", 1'b0, 1'b0, 1'b0);
        check_eq("t2_err", 32'(target_err), 32'h0);

        // 3: backpressure plus an ignored wrong-path capture
        fetch_ready = 1'b0;
        ex_valid = 1'b1; PcSel = 1'b1; BrPC = 32'h0C0;
        tick();
        bump(1'b0);
        ex_valid = 1'b0; PcSel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ex_valid = 1'b1; PcSel = 1'b1; BrPC = 32'h80;
            end else begin
                ex_valid = 1'b0; PcSel = 1'b0;
            end
            check_outs("t3_hold", 1'b1, 1'b1, 1'b1);
            check_eq("t3_pc", 32'(redirect_pc), 32'h0C0);
            tick();
        end
        ex_valid = 1'b0; PcSel = 1'b0;
        check_outs("t3_still", 1'b1, 1'b1, 1'b1);
        check_eq("t3_pc_end", 32'(redirect_pc), 32'h0C0);
        check_cnts("t3");
        fetch_ready = 1'b1;
        tick();
        check_outs("t3_flush", 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        check_outs("t3_idle", 1'b0, 1'b0, 1'b0);

        // 4: misaligned and out-of-range targets set the sticky error
        do_redirect(32'h42, 1'b0);
        check_eq("t4_mis_pc", 32'(redirect_pc), 32'h040);
        check_eq("t4_mis_err", 32'(target_err), 32'h1);
        do_redirect(32'h200, 1'b0);
        check_eq("t4_oor_pc", 32'(redirect_pc), 32'h000);
        check_eq("t4_oor_err", 32'(target_err), 32'h1);
        do_redirect(32'h44, 1'b0);
        check_eq("t4_good_pc", 32'(redirect_pc), 32'h044);
        check_eq("t4_sticky", 32'(target_err), 32'h1);
        check_cnts("t4");

        // 6: capture during the last FLUSH cycle is ignored; first IDLE cycle is taken
        ex_valid = 1'b1; PcSel = 1'b1; BrPC = 32'h0F0; fetch_ready = 1'b1;
        tick();
        bump(1'b0);
        ex_valid = 1'b0; PcSel = 1'b0;
        tick();
        tick();
        check_outs("t6_lastflush", 1'b0, 1'b1, 1'b1);
        ex_valid = 1'b1; PcSel = 1'b1; BrPC = 32'h100;
        tick();
        check_outs("t6_idle", 1'b0, 1'b0, 1'b0);
        check_eq("t6_pc_keep", 32'(redirect_pc), 32'h0F0);
        check_cnts("t6_ignored");
        BrPC = 32'h10C;
        tick();
        bump(1'b0);
        ex_valid = 1'b0; PcSel = 1'b0;
        check_outs("t6_second", 1'b1, 1'b1, 1'b1);
        check_eq("t6_pc", 32'(redirect_pc), 32'h10C);
        check_cnts("t6");
        tick();
        tick();
        tick();
        check_outs("t6_done", 1'b0, 1'b0, 1'b0);

        // 5: jump counter saturates at 15 and holds
        for (int i = 0; i < 20; i++) begin
            do_redirect(32'h20 + 32'(i) * 4, 1'b1);
            if (i == 14) check_eq("t5_at15", 32'(jump_cnt), 32'd15);
        end
        check_eq("t5_sat", 32'(jump_cnt), 32'd15);
        check_cnts("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
